spi_lcd_capture: RTL and testbench
==================================

SPI_LCD_CAPTURE -- requirements
Module: spi_lcd_capture

Interface
REQ-001 Parameter FifoDepth, default 8, byte-entry FIFO depth; power of two, minimum 2.
REQ-002 Parameter Cpol, default 0, idle SCK level; sampling is on the leading edge only, i.e. SPI mode 0 or mode 2.
REQ-003 Parameter MsbFirst, default 1; 1 = first received bit lands in data[7], 0 = first received bit lands in data[0].
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low, ports clk_i and rst_ni.
REQ-005 clk_i  input  1  capture clock; SHALL be at least 4x the SCK frequency.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 sck_i  input  1  SPI clock from the controller; asynchronous to clk_i.
REQ-008 copi_i  input  1  controller-out data line.
REQ-009 cs_ni  input  1  active-low chip select.
REQ-010 dc_i  input  1  LCD data/command select; 1 = data, 0 = command.
REQ-011 data_o  output  8  head-of-FIFO byte.
REQ-012 dc_o  output  1  dc value latched with the head-of-FIFO byte.
REQ-013 valid_o  output  1  FIFO is non-empty.
REQ-014 ready_i  input  1  consumer accepts the head entry.
REQ-015 overflow_o  output  1  sticky flag; set when a byte is dropped.
REQ-016 frame_err_o  output  1  one-cycle pulse on a partial-byte abort.
REQ-017 clear_i  input  1  clears overflow_o and byte_cnt_o.
REQ-018 byte_cnt_o  output  16  count of bytes accepted into the FIFO; wraps at 16 bits.

Function
REQ-019 sck_i, copi_i, cs_ni and dc_i SHALL each pass through a 2-flop synchronizer; all logic below uses only the synchronized copies.
REQ-020 Sample edge: synchronized SCK leaves the Cpol level while synchronized CS is low. It is detected by comparing against a third registered SCK copy.
REQ-021 On each sample edge the synchronized COPI SHALL shift into the shift register and the 3-bit bit counter SHALL increment.
REQ-022 On the edge where the bit counter wraps 7->0, {dc, byte} SHALL be pushed into the FIFO. dc is the synchronized dc_i at that cycle.
REQ-023 The pushed entry SHALL appear on valid_o/data_o no later than 2 clk_i cycles after the push cycle.
REQ-024 States: IDLE (CS high) and SHIFT (CS low). IDLE->SHIFT on the synchronized CS falling edge, which also clears the bit counter.
REQ-025 SHIFT->IDLE on the synchronized CS rising edge. If the bit counter is nonzero at that point, the partial byte SHALL be discarded and frame_err_o pulsed for exactly 1 cycle.
REQ-026 Sample edges seen in IDLE SHALL be ignored.
REQ-027 Pop rule: an entry is popped when valid_o && ready_i.
REQ-028 data_o and dc_o SHALL be stable while valid_o is high and ready_i is low.
REQ-029 A push into a full FIFO SHALL drop the byte, set overflow_o and leave byte_cnt_o unchanged.
REQ-030 If a pop and a push occur in the same cycle while the FIFO is full, both SHALL succeed and overflow_o SHALL NOT be set.
REQ-031 clear_i SHALL zero overflow_o and byte_cnt_o.
REQ-032 If clear_i coincides with an overflow, overflow_o SHALL end that cycle set.
REQ-033 If clear_i coincides with an accepted push, byte_cnt_o SHALL end that cycle at 1.
REQ-034 byte_cnt_o SHALL wrap from 0xFFFF to 0x0000 with no flag.

Reset
REQ-035 Reset values: all outputs 0; FIFO empty; state IDLE; bit counter 0; shift register 0.
REQ-036 Synchronizer flops SHALL reset as follows: SCK to Cpol, CS to 1, COPI and DC to 0.
REQ-037 Reset asserted mid-byte or mid-burst SHALL discard all partial and queued data.
REQ-038 No frame_err_o pulse SHALL be generated by reset entry or reset exit.

Structure
REQ-039 Package spi_lcd_capture_pkg SHALL hold:
- typedef capture_entry_t as packed {dc, data[7:0]};
- localparam BitsPerByte = 8;
- localparam ByteCntWidth = 16.
REQ-040 Buffering SHALL use one sub-module instance, prim_fifo_sync, of width $bits(capture_entry_t) and depth FifoDepth; everything else is inline.

Verification
REQ-041 Mode 0, SCK = clk/8, CS low, dc=1, bytes 0xA5 and 0x3C, ready_i=1 -> two pops: {1,0xA5} then {1,0x3C}; byte_cnt_o=2.
REQ-042 MsbFirst=0, send 0x01 MSB-first on the wire -> data_o=0x80.
REQ-043 CS rises after 5 bits, then a full byte 0x55 -> one frame_err_o pulse; only 0x55 queued; byte_cnt_o=1.
REQ-044 ready_i=0, send 9 bytes with FifoDepth=8 -> first 8 bytes retained in order; overflow_o=1; byte_cnt_o=8. Then clear_i -> overflow_o=0, byte_cnt_o=0.
REQ-045 FIFO full, ready_i=1 in the exact cycle of a 9th push -> no overflow; head pops; 9th byte retained.
REQ-046 rst_ni low mid-byte with 3 entries queued -> valid_o=0 next cycle. After release, a new byte 0xC3 is received correctly with no frame_err_o.

Source files
------------

// File: rtl/spi_lcd_capture_pkg.sv
// Shared types and constants for the SPI LCD capture block.
// The FIFO entry carries the D/C select alongside the captured byte.
package spi_lcd_capture_pkg;

    localparam int BitsPerByte  = 8;
    localparam int ByteCntWidth = 16;

    typedef struct packed {
        logic                   dc;
        logic [BitsPerByte-1:0] data;
    } capture_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } cap_state_e;

endpackage

// File: rtl/prim_fifo_sync.sv
// Single-clock FIFO with a registered storage array and first-word fall-through read.
// A write into a full FIFO is accepted when a read retires the head in the same cycle.
module prim_fifo_sync #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o
);

    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned AddrW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wptr_q;
    logic [PtrW:0]    rptr_q;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;

    // The extra pointer bit tells full from empty when the indices match.
    assign empty_s  = (wptr_q == rptr_q);
    assign full_s   = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign pop_s    = !empty_s && rready_i;
    assign wready_o = !full_s || pop_s;
    assign push_s   = wvalid_i && wready_o;
    assign rvalid_o = !empty_s;
    assign rdata_o  = empty_s ? {Width{1'b0}} : mem_q[rptr_q[PtrW-1:0]];

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= {AddrW{1'b0}};
            rptr_q <= {AddrW{1'b0}};
        end else begin
            if (push_s) begin
                wptr_q <= wptr_q + AddrW'(1);
            end
            if (pop_s) begin
                rptr_q <= rptr_q + AddrW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_lcd_capture.sv
// Passive SPI capture for an LCD write bus: oversamples SCK/COPI/CS/DC in the clk_i
// domain, assembles bytes and queues {dc, byte} for a ready/valid consumer.
module spi_lcd_capture
    import spi_lcd_capture_pkg::*;
#(
    parameter int unsigned FifoDepth = 8,
    parameter bit          Cpol      = 1'b0,
    parameter bit          MsbFirst  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    sck_i,
    input  logic                    copi_i,
    input  logic                    cs_ni,
    input  logic                    dc_i,
    output logic [BitsPerByte-1:0]  data_o,
    output logic                    dc_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overflow_o,
    output logic                    frame_err_o,
    input  logic                    clear_i,
    output logic [ByteCntWidth-1:0] byte_cnt_o
);

    logic sck_q1, sck_q2, sck_q3;
    logic cs_q1, cs_q2, cs_q3;
    logic copi_q1, copi_q2;
    logic dc_q1, dc_q2;

    cap_state_e             state_q;
    logic [2:0]             bit_cnt_q;
    logic [BitsPerByte-1:0] shift_q;
    logic                   frame_err_q;
    logic                   overflow_q;
    logic [ByteCntWidth-1:0] byte_cnt_q;

    logic                   sample_edge_s;
    logic                   cs_fall_s;
    logic                   cs_rise_s;
    logic [BitsPerByte-1:0] shift_in_s;
    logic                   push_s;
    logic                   accept_s;
    logic                   drop_s;
    logic                   fifo_wready_s;
    capture_entry_t         push_entry_s;
    capture_entry_t         head_entry_s;

    // Two-flop synchronizers; the third SCK/CS stage is only used for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q1  <= Cpol;
            sck_q2  <= Cpol;
            sck_q3  <= Cpol;
            cs_q1   <= 1'b1;
            cs_q2   <= 1'b1;
            cs_q3   <= 1'b1;
            copi_q1 <= 1'b0;
            copi_q2 <= 1'b0;
            dc_q1   <= 1'b0;
            dc_q2   <= 1'b0;
        end else begin
            sck_q1  <= sck_i;
            sck_q2  <= sck_q1;
            sck_q3  <= sck_q2;
            cs_q1   <= cs_ni;
            cs_q2   <= cs_q1;
            cs_q3   <= cs_q2;
            copi_q1 <= copi_i;
            copi_q2 <= copi_q1;
            dc_q1   <= dc_i;
            dc_q2   <= dc_q1;
        end
    end

    assign sample_edge_s = (sck_q2 != Cpol) && (sck_q3 == Cpol) && !cs_q2;
    assign cs_fall_s     = cs_q3 && !cs_q2;
    assign cs_rise_s     = !cs_q3 && cs_q2;
    assign shift_in_s    = MsbFirst ? {shift_q[BitsPerByte-2:0], copi_q2}
                                    : {copi_q2, shift_q[BitsPerByte-1:1]};

    // The eighth sample edge of a frame completes a byte and pushes it.
    assign push_s            = (state_q == ST_SHIFT) && sample_edge_s && (bit_cnt_q == 3'd7);
    assign push_entry_s.dc   = dc_q2;
    assign push_entry_s.data = shift_in_s;
    assign accept_s          = push_s && fifo_wready_s;
    assign drop_s            = push_s && !fifo_wready_s;

    // Frame state machine: bit counting, shifting and partial-byte abort detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= {BitsPerByte{1'b0}};
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_s) begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= (bit_cnt_q != 3'd0);
                        bit_cnt_q   <= 3'd0;
                    end else if (sample_edge_s) begin
                        shift_q   <= shift_in_s;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    bit_cnt_q <= 3'd0;
                end
            endcase
        end
    end

    // Sticky overflow and accepted-byte counter; a same-cycle event wins over clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            byte_cnt_q <= {ByteCntWidth{1'b0}};
        end else begin
            if (drop_s) begin
                overflow_q <= 1'b1;
            end else if (clear_i) begin
                overflow_q <= 1'b0;
            end
            if (clear_i) begin
                byte_cnt_q <= accept_s ? ByteCntWidth'(1) : {ByteCntWidth{1'b0}};
            end else if (accept_s) begin
                byte_cnt_q <= byte_cnt_q + ByteCntWidth'(1);
            end
        end
    end

    prim_fifo_sync #(
        .Width ($bits(capture_entry_t)),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wvalid_i (push_s),
        .wready_o (fifo_wready_s),
        .wdata_i  (push_entry_s),
        .rvalid_o (valid_o),
        .rready_i (ready_i),
        .rdata_o  (head_entry_s)
    );

    assign data_o      = head_entry_s.data;
    assign dc_o        = head_entry_s.dc;
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;
    assign byte_cnt_o  = byte_cnt_q;

endmodule

// File: tb/tb_spi_lcd_capture.sv
// Directed bench for spi_lcd_capture: an MSB-first instance carries most scenarios,
// a second LSB-first instance shares the bus for the bit-order case.
module tb_spi_lcd_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic copi = 1'b0;
    logic cs_n = 1'b1;
    logic dc = 1'b0;
    logic ready = 1'b0;
    logic clear = 1'b0;

    logic [7:0]  data_m, data_l;
    logic        dc_m, dc_l, valid_m, valid_l, ovf_m, ovf_l, fe_m, fe_l;
    logic [15:0] cnt_m, cnt_l;

    int n_checks = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    logic [8:0] popq[$];
    logic [8:0] popq_l[$];

    spi_lcd_capture #(.FifoDepth(8), .Cpol(1'b0), .MsbFirst(1'b1)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .copi_i(copi), .cs_ni(cs_n), .dc_i(dc),
        .data_o(data_m), .dc_o(dc_m), .valid_o(valid_m), .ready_i(ready),
        .overflow_o(ovf_m), .frame_err_o(fe_m), .clear_i(clear), .byte_cnt_o(cnt_m)
    );

    spi_lcd_capture #(.FifoDepth(8), .Cpol(1'b0), .MsbFirst(1'b0)) dut_l (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .copi_i(copi), .cs_ni(cs_n), .dc_i(dc),
        .data_o(data_l), .dc_o(dc_l), .valid_o(valid_l), .ready_i(ready),
        .overflow_o(ovf_l), .frame_err_o(fe_l), .clear_i(clear), .byte_cnt_o(cnt_l)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; pops and pulses are logged just after it.
    always @(negedge clk) begin
        #1;
        if (valid_m && ready) popq.push_back({dc_m, data_m});
        if (valid_l && ready) popq_l.push_back({dc_l, data_l});
        if (fe_m) fe_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            copi = b[i];
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_end();
        tick(4);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; copi = 1'b0; dc = 1'b0; ready = 1'b0; clear = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        popq.delete();
        popq_l.delete();
        fe_cnt = 0;
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_m); end
        n_checks++; if (data_m !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_m); end
        n_checks++; if (dc_m !== 1'b0) begin n_fail++; $display("FAIL reset_dc: got %b want 0", dc_m); end
        n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_m); end
        n_checks++; if (fe_m !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", fe_m); end
        n_checks++; if (cnt_m !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt_m); end
        rst_n = 1'b1;
        tick(6);
        n_checks++; if (valid_m !== 1'b0 || fe_cnt !== 0) begin n_fail++; $display("FAIL reset_exit: valid %b fe_cnt %0d want 0/0", valid_m, fe_cnt); end
    endtask

    task automatic test_basic();
        logic [8:0] got;
        do_reset();
        ready = 1'b1; dc = 1'b1;
        cs_begin();
        send_bits(8'hA5, 8);
        send_bits(8'h3C, 8);
        cs_end();
        n_checks++; if (popq.size() !== 2) begin n_fail++; $display("FAIL basic_npop: got %0d want 2", popq.size()); end
        got = (popq.size() > 0) ? popq[0] : 9'h000;
        n_checks++; if (got !== 9'h1A5) begin n_fail++; $display("FAIL basic_pop0: got %h want 1a5", got); end
        got = (popq.size() > 1) ? popq[1] : 9'h000;
        n_checks++; if (got !== 9'h13C) begin n_fail++; $display("FAIL basic_pop1: got %h want 13c", got); end
        n_checks++; if (cnt_m !== 16'd2) begin n_fail++; $display("FAIL basic_cnt: got %0d want 2", cnt_m); end
        n_checks++; if (valid_m !== 1'b0 || ovf_m !== 1'b0 || fe_cnt !== 0) begin n_fail++; $display("FAIL basic_idle: valid %b ovf %b fe %0d want 0/0/0", valid_m, ovf_m, fe_cnt); end
    endtask

    task automatic test_lsb_first();
        logic [8:0] got;
        do_reset();
        ready = 1'b1; dc = 1'b1;
        cs_begin();
        send_bits(8'h01, 8);
        cs_end();
        got = (popq_l.size() > 0) ? popq_l[0] : 9'h000;
        n_checks++; if (got !== 9'h180) begin n_fail++; $display("FAIL lsb_data: got %h want 180", got); end
        got = (popq.size() > 0) ? popq[0] : 9'h000;
        n_checks++; if (got !== 9'h101) begin n_fail++; $display("FAIL msb_data: got %h want 101", got); end
    endtask

    task automatic test_frame_err();
        logic [8:0] got;
        do_reset();
        ready = 1'b1; dc = 1'b0;
        cs_begin();
        send_bits(8'hF8, 5);
        cs_end();
        cs_begin();
        send_bits(8'h55, 8);
        cs_end();
        n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt); end
        n_checks++; if (popq.size() !== 1) begin n_fail++; $display("FAIL ferr_npop: got %0d want 1", popq.size()); end
        got = (popq.size() > 0) ? popq[0] : 9'h1FF;
        n_checks++; if (got !== 9'h055) begin n_fail++; $display("FAIL ferr_pop: got %h want 055", got); end
        n_checks++; if (cnt_m !== 16'd1) begin n_fail++; $display("FAIL ferr_cnt: got %0d want 1", cnt_m); end
    endtask

    task automatic test_overflow();
        logic [8:0] got;
        do_reset();
        ready = 1'b0; dc = 1'b1;
        cs_begin();
        for (int k = 0; k < 9; k++) send_bits(8'h10 + 8'(k), 8);
        cs_end();
        n_checks++; if (ovf_m !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf_m); end
        n_checks++; if (cnt_m !== 16'd8) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 8", cnt_m); end
        n_checks++; if (valid_m !== 1'b1 || data_m !== 8'h10) begin n_fail++; $display("FAIL ovf_head: valid %b data %h want 1/10", valid_m, data_m); end
        ready = 1'b1;
        tick(12);
        ready = 1'b0;
        n_checks++; if (popq.size() !== 8) begin n_fail++; $display("FAIL ovf_npop: got %0d want 8", popq.size()); end
        for (int k = 0; k < 8; k++) begin
            got = (popq.size() > k) ? popq[k] : 9'h000;
            n_checks++; if (got !== (9'h110 + 9'(k))) begin n_fail++; $display("FAIL ovf_pop%0d: got %h want %h", k, got, 9'h110 + 9'(k)); end
        end
        n_checks++; if (ovf_m !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf_m); end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        n_checks++; if (ovf_m !== 1'b0 || cnt_m !== 16'd0) begin n_fail++; $display("FAIL ovf_clear: ovf %b cnt %0d want 0/0", ovf_m, cnt_m); end
    endtask

    task automatic test_full_pop();
        logic [8:0] got;
        do_reset();
        ready = 1'b0; dc = 1'b1;
        cs_begin();
        for (int k = 0; k < 8; k++) send_bits(8'h20 + 8'(k), 8);
        send_bits(8'h28, 7);
        // The 8th sample edge reaches the FIFO three posedges after SCK rises.
        copi = 1'b0;
        tick(4);
        sck = 1'b1;
        tick(2);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        sck = 1'b0;
        cs_end();
        n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL full_ovf: got %b want 0", ovf_m); end
        n_checks++; if (cnt_m !== 16'd9) begin n_fail++; $display("FAIL full_cnt: got %0d want 9", cnt_m); end
        n_checks++; if (popq.size() !== 1 || data_m !== 8'h21) begin n_fail++; $display("FAIL full_head: npop %0d data %h want 1/21", popq.size(), data_m); end
        ready = 1'b1;
        tick(12);
        ready = 1'b0;
        n_checks++; if (popq.size() !== 9) begin n_fail++; $display("FAIL full_npop: got %0d want 9", popq.size()); end
        for (int k = 0; k < 9; k++) begin
            got = (popq.size() > k) ? popq[k] : 9'h000;
            n_checks++; if (got !== (9'h120 + 9'(k))) begin n_fail++; $display("FAIL full_pop%0d: got %h want %h", k, got, 9'h120 + 9'(k)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] got;
        do_reset();
        ready = 1'b0; dc = 1'b1;
        cs_begin();
        send_bits(8'h01, 8);
        send_bits(8'h02, 8);
        send_bits(8'h03, 8);
        send_bits(8'hF0, 4);
        n_checks++; if (valid_m !== 1'b1 || cnt_m !== 16'd3) begin n_fail++; $display("FAIL rmid_pre: valid %b cnt %0d want 1/3", valid_m, cnt_m); end
        fe_cnt = 0;
        rst_n = 1'b0;
        tick(1);
        n_checks++; if (valid_m !== 1'b0 || cnt_m !== 16'd0) begin n_fail++; $display("FAIL rmid_flush: valid %b cnt %0d want 0/0", valid_m, cnt_m); end
        cs_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        popq.delete();
        cs_begin();
        send_bits(8'hC3, 8);
        cs_end();
        ready = 1'b1;
        tick(6);
        ready = 1'b0;
        got = (popq.size() > 0) ? popq[0] : 9'h000;
        n_checks++; if (popq.size() !== 1 || got !== 9'h1C3) begin n_fail++; $display("FAIL rmid_byte: npop %0d got %h want 1/1c3", popq.size(), got); end
        n_checks++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL rmid_ferr: got %0d want 0", fe_cnt); end
        n_checks++; if (cnt_m !== 16'd1) begin n_fail++; $display("FAIL rmid_cnt: got %0d want 1", cnt_m); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lsb_first();
        test_frame_err();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
